// File: rtl/cpu_result_uart_tx.sv
// cpu_result_uart_tx
//   Captures each rising edge of the CPU result-valid strobe into a small FIFO and
//   transmits the queued bytes as 8N1 UART frames, LSB first.
//
// Ports
//   CLK         system clock (shared with the CPU)
//   ASYN_CLR_N  asynchronous active-low reset
//   DOUT        result-valid strobe; one push per 0->1 transition
//   OUT_RESULT  result byte, sampled on the push edge
//   TXD         registered serial output, idle high
//   TX_BUSY     high while a frame (start, data or stop) is in progress
//   FIFO_FULL   FIFO holds FIFO_DEPTH entries
//   FIFO_COUNT  number of queued entries
//   OVERFLOW    sticky flag, set when a push is dropped; only reset clears it
module cpu_result_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                          CLK,
  input  logic                          ASYN_CLR_N,
  input  logic                          DOUT,
  input  logic [7:0]                    OUT_RESULT,
  output logic                          TXD,
  output logic                          TX_BUSY,
  output logic                          FIFO_FULL,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
  output logic                          OVERFLOW
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
  localparam logic [PtrW:0]   Depth  = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Capture and FIFO state
  logic            dout_q;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            overflow_q, overflow_d;

  // Transmitter state
  state_e          state_q, state_d;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            txd_q, txd_d;

  logic push, push_ok, pop, full, empty, bit_end;

  assign full    = (count_q == Depth);
  assign empty   = (count_q == '0);
  assign push    = DOUT & ~dout_q;
  // A push into a full FIFO is only accepted when a pop frees a slot on the same edge.
  assign push_ok = push & (~full | pop);
  assign bit_end = (bit_cnt_q == CntMax);

  // FIFO next state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push_ok && !pop)      count_d = count_q + (PtrW + 1)'(1);
    else if (!push_ok && pop) count_d = count_q - (PtrW + 1)'(1);
    if (push && !push_ok) overflow_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge ASYN_CLR_N) begin
    if (!ASYN_CLR_N) begin
      dout_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      dout_q     <= DOUT;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= OUT_RESULT;
  end

  // FSM state register
  always_ff @(posedge CLK or negedge ASYN_CLR_N) begin
    if (!ASYN_CLR_N) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          bit_cnt_d = '0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = StData;
        end else begin
          bit_cnt_d = bit_cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output: TXD is computed from the next state so the line comes straight off a flop.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      StStart: txd_d = 1'b0;
      StData:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  assign TXD        = txd_q;
  assign TX_BUSY    = (state_q != StIdle);
  assign FIFO_FULL  = full;
  assign FIFO_COUNT = count_q;
  assign OVERFLOW   = overflow_q;

endmodule

// File: tb/tb_cpu_result_uart_tx.sv
// Bench for cpu_result_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A queue/frame-time model predicts every output each cycle; a line receiver
// decodes TXD so transmitted bytes can be compared against literal lists.
module tb_cpu_result_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  typedef logic [7:0] bq_t [$];

  logic       CLK;
  logic       ASYN_CLR_N;
  logic       DOUT;
  logic [7:0] OUT_RESULT;
  logic       TXD;
  logic       TX_BUSY;
  logic       FIFO_FULL;
  logic [2:0] FIFO_COUNT;
  logic       OVERFLOW;

  cpu_result_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .CLK       (CLK),
    .ASYN_CLR_N(ASYN_CLR_N),
    .DOUT      (DOUT),
    .OUT_RESULT(OUT_RESULT),
    .TXD       (TXD),
    .TX_BUSY   (TX_BUSY),
    .FIFO_FULL (FIFO_FULL),
    .FIFO_COUNT(FIFO_COUNT),
    .OVERFLOW  (OVERFLOW)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- behavioural model ----------------
  logic [7:0] m_q [$];
  logic [7:0] m_byte;
  bit         m_busy;
  int         m_k;
  bit         m_dout_q;
  bit         m_ovf;

  task automatic model_reset();
    m_q.delete();
    m_byte   = 8'h00;
    m_busy   = 1'b0;
    m_k      = 0;
    m_dout_q = 1'b0;
    m_ovf    = 1'b0;
  endtask

  task automatic model_step();
    bit push;
    bit pop;
    int pre;
    pre      = m_q.size();
    push     = DOUT && !m_dout_q;
    m_dout_q = DOUT;
    pop      = 1'b0;
    if (m_busy) begin
      m_k++;
      if (m_k == FRAME) begin
        if (pre > 0) pop = 1'b1;
        else m_busy = 1'b0;
      end
    end else if (pre > 0) begin
      pop = 1'b1;
    end
    if (pop) begin
      m_byte = m_q.pop_front();
      m_busy = 1'b1;
      m_k    = 0;
    end
    if (push) begin
      if (pre < DEPTH || pop) m_q.push_back(OUT_RESULT);
      else m_ovf = 1'b1;
    end
  endtask

  // {TXD, TX_BUSY, FIFO_FULL, OVERFLOW, FIFO_COUNT}
  function automatic logic [6:0] model_out();
    logic txd;
    int   j;
    txd = 1'b1;
    if (m_busy) begin
      j = m_k / CPB;
      if (j == 0) txd = 1'b0;
      else if (j == 9) txd = 1'b1;
      else txd = m_byte[j-1];
    end
    return {txd, m_busy, (m_q.size() == DEPTH), m_ovf, 3'(m_q.size())};
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge CLK or negedge ASYN_CLR_N);
      if (!ASYN_CLR_N) model_reset();
      else model_step();
    end
  end

  // ---------------- line receiver ----------------
  logic [7:0] rx_q [$];
  bit         rx_active;
  int         rx_t;
  logic [7:0] rx_sh;

  initial begin
    rx_active = 1'b0;
    rx_t      = 0;
    rx_sh     = 8'h00;
    forever begin
      @(negedge CLK);
      if (!ASYN_CLR_N) begin
        rx_active = 1'b0;
      end else begin
        if (!rx_active) begin
          if (TXD == 1'b0) begin
            rx_active = 1'b1;
            rx_t      = 0;
          end
        end else begin
          rx_t++;
        end
        if (rx_active) begin
          if (rx_t >= CPB + 1 && rx_t <= 8 * CPB + 1 && (rx_t % CPB) == 1)
            rx_sh[rx_t / CPB - 1] = TXD;
          if (rx_t == 9 * CPB + 1) rx_q.push_back(rx_sh);
          if (rx_t == FRAME - 1) rx_active = 1'b0;
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  int total;
  int bad;
  int busy_run;
  int last_run;
  int peak;
  bq_t exp_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare every output with the model.
  task automatic tick();
    @(negedge CLK);
    check("outputs", {25'b0, TXD, TX_BUSY, FIFO_FULL, OVERFLOW, FIFO_COUNT},
          {25'b0, model_out()});
    if (TX_BUSY) begin
      busy_run++;
    end else begin
      if (busy_run > 0) last_run = busy_run;
      busy_run = 0;
    end
    if (int'(FIFO_COUNT) > peak) peak = int'(FIFO_COUNT);
  endtask

  task automatic pulse(input logic [7:0] v);
    DOUT       = 1'b1;
    OUT_RESULT = v;
    tick();
    DOUT = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((TX_BUSY || FIFO_COUNT != 3'd0) && n < budget) begin
      tick();
      n++;
    end
    check("idle_reached", {31'b0, TX_BUSY | (FIFO_COUNT != 3'd0)}, 32'd0);
    repeat (3) tick();
  endtask

  task automatic check_rx(input string name, input int start, input bq_t exp);
    check({name, "_len"}, rx_q.size() - start, exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (start + i < rx_q.size()) check({name, "_byte"}, {24'b0, rx_q[start + i]}, {24'b0, exp[i]});
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [9:0] pat;
    int         s;
    total      = 0;
    bad        = 0;
    busy_run   = 0;
    last_run   = 0;
    peak       = 0;
    ASYN_CLR_N = 1'b0;
    DOUT       = 1'b0;
    OUT_RESULT = 8'h00;

    // Reset held while DOUT toggles
    for (int i = 0; i < 6; i++) begin
      DOUT       = i[0];
      OUT_RESULT = 8'h77;
      tick();
      check("rst_txd", {31'b0, TXD}, 32'd1);
      check("rst_count", {29'b0, FIFO_COUNT}, 32'd0);
      check("rst_busy", {31'b0, TX_BUSY}, 32'd0);
    end
    DOUT = 1'b0;
    tick();
    ASYN_CLR_N = 1'b1;
    repeat (2) tick();

    // Single byte 0xA5, DOUT high 5 cycles
    s   = rx_q.size();
    pat = 10'b11_0100_1010;
    DOUT       = 1'b1;
    OUT_RESULT = 8'hA5;
    tick();
    check("sb_txd_pre", {31'b0, TXD}, 32'd1);
    check("sb_count", {29'b0, FIFO_COUNT}, 32'd1);
    tick();
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) tick();
      check("sb_bit", {31'b0, TXD}, {31'b0, pat[i / CPB]});
      if (i == 3) DOUT = 1'b0;
    end
    wait_idle(200);
    check("sb_busy_len", last_run, 32'd40);
    exp_q.delete();
    exp_q.push_back(8'hA5);
    check_rx("rx_single", s, exp_q);

    // Burst of three, back-to-back frames
    s    = rx_q.size();
    peak = 0;
    for (int b = 1; b <= 3; b++) begin
      pulse(8'(b));
      tick();
    end
    wait_idle(300);
    check("burst_busy_len", last_run, 32'd120);
    check("burst_peak", peak, 32'd2);
    exp_q.delete();
    for (int b = 1; b <= 3; b++) exp_q.push_back(8'(b));
    check_rx("rx_burst", s, exp_q);

    // Reset asserted in the middle of a frame
    s = rx_q.size();
    pulse(8'h33);
    pulse(8'h44);
    repeat (10) tick();
    check("mr_count_before", {29'b0, FIFO_COUNT}, 32'd1);
    @(posedge CLK);
    #1 ASYN_CLR_N = 1'b0;
    #1;
    check("mr_txd", {31'b0, TXD}, 32'd1);
    check("mr_busy", {31'b0, TX_BUSY}, 32'd0);
    check("mr_count", {29'b0, FIFO_COUNT}, 32'd0);
    repeat (3) tick();
    ASYN_CLR_N = 1'b1;
    wait_idle(10);
    exp_q.delete();
    check_rx("rx_after_reset", s, exp_q);

    // Overflow: five pushes while a frame is running
    s = rx_q.size();
    pulse(8'hEE);
    for (int b = 0; b < 4; b++) pulse(8'h10 + 8'(b));
    check("ovf_count_full", {29'b0, FIFO_COUNT}, 32'd4);
    check("ovf_full", {31'b0, FIFO_FULL}, 32'd1);
    check("ovf_before", {31'b0, OVERFLOW}, 32'd0);
    pulse(8'h14);
    check("ovf_set", {31'b0, OVERFLOW}, 32'd1);
    check("ovf_count_kept", {29'b0, FIFO_COUNT}, 32'd4);
    wait_idle(400);
    exp_q.delete();
    exp_q.push_back(8'hEE);
    for (int b = 0; b < 4; b++) exp_q.push_back(8'h10 + 8'(b));
    check_rx("rx_overflow", s, exp_q);
    check("ovf_sticky", {31'b0, OVERFLOW}, 32'd1);

    // Reset clears OVERFLOW; DOUT high at release gives a push on the first edge
    s = rx_q.size();
    ASYN_CLR_N = 1'b0;
    tick();
    check("ovf_cleared", {31'b0, OVERFLOW}, 32'd0);
    DOUT       = 1'b1;
    OUT_RESULT = 8'h5A;
    tick();
    ASYN_CLR_N = 1'b1;
    tick();
    check("rel_push", {29'b0, FIFO_COUNT}, 32'd1);
    DOUT = 1'b0;
    wait_idle(100);
    exp_q.delete();
    exp_q.push_back(8'h5A);
    check_rx("rx_release", s, exp_q);

    // Push exactly on the stop->start pop edge while full
    s          = rx_q.size();
    DOUT       = 1'b1;
    OUT_RESULT = 8'h20;
    for (int n = 1; n <= 42; n++) begin
      tick();
      DOUT = 1'b0;
      if (n >= 2 && n <= 8 && (n % 2) == 0) begin
        DOUT       = 1'b1;
        OUT_RESULT = 8'h20 + 8'(n / 2);
      end
      if (n == 41) begin
        check("sim_full_before", {30'b0, FIFO_FULL, OVERFLOW}, 32'd2);
        DOUT       = 1'b1;
        OUT_RESULT = 8'h25;
      end
    end
    check("sim_count", {29'b0, FIFO_COUNT}, 32'd4);
    check("sim_ovf", {31'b0, OVERFLOW}, 32'd0);
    wait_idle(400);
    exp_q.delete();
    for (int b = 0; b < 6; b++) exp_q.push_back(8'h20 + 8'(b));
    check_rx("rx_simul", s, exp_q);

    // Pointer wrap: ten spaced bytes
    s = rx_q.size();
    for (int b = 0; b < 10; b++) begin
      DOUT       = 1'b1;
      OUT_RESULT = 8'(b);
      tick();
      DOUT = 1'b0;
      repeat (43) tick();
    end
    wait_idle(100);
    exp_q.delete();
    for (int b = 0; b < 10; b++) exp_q.push_back(8'(b));
    check_rx("rx_wrap", s, exp_q);
    check("wrap_ovf", {31'b0, OVERFLOW}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
